// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: parametrised multicycle RISC-V datapath with a req/ready handshake
// toward a variable-latency unified memory. Define MC_DP_MEM_TIMEOUT_EN to add the access watchdog.
module mc_datapath_hs #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            adr_src,
  input  logic            ir_write,
  input  logic [1:0]      result_src,
  input  logic [3:0]      alu_control,
  input  logic [1:0]      alu_src_a,
  input  logic [1:0]      alu_src_b,
  input  logic [3:0]      imm_src,
  input  logic            imm_in,
  input  logic            reg_write,
  input  logic            reg_src,
  input  logic            mem_start,
  input  logic            mem_we,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wen,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_done,
  output logic            busy,
  output logic            mem_err,
  output logic            zero,
  output logic            sign,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);
  localparam int unsigned     IDX_W = $clog2(NREGS);
  localparam int unsigned     SH_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);

  if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
    $error("mc_datapath_hs: NREGS must be 16 or 32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mc_datapath_hs: TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] pc_q, old_pc_q, ir_q, data_q;
  logic [XLEN-1:0] a_p1, b_p1, alu_out_p2;
  logic [XLEN-1:0] rf [NREGS];
  logic            fetch_q, vld_p1;
  logic            start, complete, timeout_hit;
  logic [XLEN-1:0] rs1_val, rs2_val, src_a, src_b, imm_ext, alu_result, result, wd;
  logic            rd_ok;

  // x0 and indices beyond the implemented file read as zero
  function automatic logic [XLEN-1:0] rf_rd(input logic [4:0] idx);
    if (idx == 5'd0 || 32'(idx) >= NREGS) return '0;
    return rf[idx[IDX_W-1:0]];
  endfunction

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                             input logic signed [XLEN-1:0] x,
                                             input logic signed [XLEN-1:0] y);
    logic [SH_W-1:0] sh;
    sh = y[SH_W-1:0];
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return XLEN'(x < y);
      4'd6:    return XLEN'($unsigned(x) < $unsigned(y));
      4'd7:    return x << sh;
      4'd8:    return $unsigned(x) >> sh;
      4'd9:    return x >>> sh;
      default: return y;
    endcase
  endfunction

  // 0-4: I/S/B/U/J immediates; 5-8: lb/lh/lbu/lhu load extension; others pass through
  function automatic logic [XLEN-1:0] ext_fn(input logic [3:0] sel, input logic [XLEN-1:0] v);
    case (sel)
      4'd0:    return XLEN'($signed(v[31:20]));
      4'd1:    return XLEN'($signed({v[31:25], v[11:7]}));
      4'd2:    return XLEN'($signed({v[31], v[7], v[30:25], v[11:8], 1'b0}));
      4'd3:    return XLEN'($signed({v[31:12], 12'b0}));
      4'd4:    return XLEN'($signed({v[31], v[19:12], v[20], v[30:21], 1'b0}));
      4'd5:    return XLEN'($signed(v[7:0]));
      4'd6:    return XLEN'($signed(v[15:0]));
      4'd7:    return XLEN'(v[7:0]);
      4'd8:    return XLEN'(v[15:0]);
      default: return v;
    endcase
  endfunction

  assign rs1_val  = rf_rd(ir_q[19:15]);
  assign rs2_val  = rf_rd(ir_q[24:20]);
  assign dbg_data = rf_rd(dbg_sel);
  assign imm_ext  = ext_fn(imm_src, imm_in ? data_q : ir_q);

  always_comb begin
    src_a = a_p1;
    case (alu_src_a)
      2'd0:    src_a = pc_q;
      2'd1:    src_a = old_pc_q;
      default: src_a = a_p1;
    endcase
    src_b = b_p1;
    case (alu_src_b)
      2'd1:    src_b = imm_ext;
      2'd2:    src_b = XLEN'(4);
      default: src_b = b_p1;
    endcase
  end

  assign alu_result = alu_fn(alu_control, src_a, src_b);
  assign zero       = (alu_result == '0);
  assign sign       = alu_result[XLEN-1];

  always_comb begin
    result = alu_out_p2;
    case (result_src)
      2'd1:    result = imm_ext;
      2'd2:    result = alu_result;
      2'd3:    result = src_b;
      default: result = alu_out_p2;
    endcase
  end

  assign wd    = reg_src ? pc_q : result;
  assign rd_ok = (ir_q[11:7] != 5'd0) && (32'(ir_q[11:7]) < NREGS);

  // Memory-access FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_start) state_nxt = WAIT;
      WAIT:    if (mem_ready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    start    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE:    start = mem_start;
      WAIT: begin
        busy     = 1'b1;
        complete = mem_ready;
      end
      default: ;
    endcase
  end

  assign mem_req  = busy;
  assign mem_done = vld_p1;

  // Access latch and completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      fetch_q   <= 1'b0;
      vld_p1    <= 1'b0;
      data_q    <= '0;
      ir_q      <= NOP;
      old_pc_q  <= '0;
    end else begin
      vld_p1 <= complete;
      if (start) begin
        mem_addr  <= adr_src ? result : pc_q;
        mem_wdata <= b_p1;
        mem_wen   <= mem_we;
        fetch_q   <= ir_write;
      end
      if (complete) begin
        data_q <= mem_rdata;
        if (fetch_q) begin
          ir_q     <= mem_rdata;
          old_pc_q <= pc_q;
        end
      end
    end
  end

  // Architectural state: blocked while an access is open
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      rf   <= '{default: '0};
    end else begin
      if (pc_write && !busy) pc_q <= result;
      if (reg_write && !busy && rd_ok) rf[ir_q[7 +: IDX_W]] <= wd;
    end
  end

  // Operand and ALU-result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p1       <= '0;
      b_p1       <= '0;
      alu_out_p2 <= '0;
    end else begin
      a_p1       <= rs1_val;
      b_p1       <= rs2_val;
      alu_out_p2 <= alu_result;
    end
  end

`ifdef MC_DP_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && !mem_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign mem_err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != WAIT || timeout_hit) wd_cnt <= '0;
      else if (!mem_ready)              wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  assign pc    = pc_q;
  assign instr = ir_q;
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Bench for mc_datapath_hs: directed handshake cases plus random controller-level
// operations checked against an architectural model (PC, IR, OldPC, Data, register file).
module tb_mc_datapath_hs;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, adr_src, ir_write, imm_in, reg_write, reg_src, mem_start, mem_we;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [3:0]  alu_control, imm_src;
  logic        mem_req, mem_wen, mem_ready, mem_done, busy, mem_err, zero, sign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr, dbg_data;
  logic [4:0]  dbg_sel;

  always #5 clk = ~clk;

  mc_datapath_hs #(.XLEN(XLEN), .NREGS(NREGS), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .result_src(result_src), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .imm_in(imm_in), .reg_write(reg_write),
    .reg_src(reg_src), .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy), .mem_err(mem_err),
    .zero(zero), .sign(sign), .pc(pc), .instr(instr), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Architectural reference model
  logic [31:0] m_pc, m_old_pc, m_ir, m_data;
  logic [31:0] m_rf [32];
  logic        m_err;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    pc_write = 0; adr_src = 0; ir_write = 0; result_src = 0; alu_control = 0;
    alu_src_a = 0; alu_src_b = 0; imm_src = 0; imm_in = 0; reg_write = 0;
    reg_src = 0; mem_start = 0; mem_we = 0; mem_ready = 0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = NOP; m_old_pc = 0; m_data = 0; m_err = 0;
    foreach (m_rf[i]) m_rf[i] = 0;
  endtask

  function automatic logic [31:0] m_rd(input int idx);
    if (idx == 0 || idx >= int'(NREGS)) return 32'd0;
    return m_rf[idx];
  endfunction

  task automatic m_wr(input int idx, input logic [31:0] v);
    if (idx != 0 && idx < int'(NREGS)) m_rf[idx] = v;
  endtask

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] load_ext(input int kind, input logic [31:0] d);
    case (kind)
      5:       return {{24{d[7]}}, d[7:0]};
      6:       return {{16{d[15]}}, d[15:0]};
      7:       return {24'd0, d[7:0]};
      8:       return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input int op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      0:       return x + y;
      1:       return x - y;
      2:       return x & y;
      3:       return x | y;
      4:       return x ^ y;
      default: return y;
    endcase
  endfunction

  task automatic check_arch(input int idx);
    logic [31:0] diff;
    diff = m_pc - 32'd4;
    dbg_sel = 5'(idx); alu_src_a = 0; alu_src_b = 2; alu_control = 1;
    #1;
    chk("pc", pc, m_pc);
    chk("instr", instr, m_ir);
    chk("rf_dbg", dbg_data, m_rd(idx));
    chk("zero_flag", zero, diff == 32'd0);
    chk("sign_flag", sign, diff[31]);
    chk("busy_idle", busy, 1'b0);
    tick();
    idle_ctl();
  endtask

  // One memory access; caller has already set the controls that form `result`
  task automatic do_access(input logic fetch, input logic we, input logic asrc, input int waits,
                           input logic noise, input logic [31:0] rdata, input logic [31:0] exp_addr);
    logic [31:0] exp_wdata;
    int busy_n, done_n;
    exp_wdata = m_rd(int'(m_ir[24:20]));
    busy_n = 0; done_n = 0;
    mem_start = 1; ir_write = fetch; mem_we = we; adr_src = asrc;
    tick();
    mem_start = 0; ir_write = 0; mem_we = 0;
    chk("req_after_start", mem_req, 1'b1);
    for (int w = 0; w <= waits; w++) begin
      busy_n += int'(busy);
      done_n += int'(mem_done);
      chk("addr_hold", mem_addr, exp_addr);
      chk("wdata_hold", mem_wdata, exp_wdata);
      chk("wen_hold", mem_wen, we);
      if (noise) begin
        pc_write = 1; reg_write = 1; mem_start = 1; ir_write = 1'($urandom);
        adr_src = 1'($urandom); result_src = 2'($urandom); alu_src_a = 2'($urandom);
        reg_src = 1'($urandom);
      end
      mem_ready = (w == waits);
      mem_rdata = (w == waits) ? rdata : $urandom;
      tick();
    end
    idle_ctl();
    done_n += int'(mem_done);
    chk("done_at_end", mem_done, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    m_data = rdata;
    if (fetch) begin
      m_old_pc = m_pc;
      m_ir = rdata;
    end
    tick();
    done_n += int'(mem_done);
    chk("busy_cycles", busy_n, waits + 1);
    chk("done_count", done_n, 1);
    chk("busy_stays_low", busy, 1'b0);
  endtask

  task automatic op_fetch(input int waits, input logic noise, input logic [31:0] rdata);
    do_access(1'b1, 1'b0, 1'b0, waits, noise, rdata, m_pc);
  endtask

  task automatic op_load(input int waits, input logic noise, input logic we);
    result_src = 3; alu_src_b = 1; imm_src = 0; imm_in = 0;
    do_access(1'b0, we, 1'b1, waits, noise, $urandom, imm_i(m_ir));
  endtask

  task automatic op_pc_inc();
    result_src = 2; alu_src_a = 0; alu_src_b = 2; alu_control = 0; pc_write = 1;
    tick(); idle_ctl();
    m_pc = m_pc + 32'd4;
  endtask

  task automatic op_pc_imm();
    result_src = 3; alu_src_b = 1; imm_src = 0; pc_write = 1;
    tick(); idle_ctl();
    m_pc = imm_i(m_ir);
  endtask

  task automatic op_rf_link(input logic use_pc);
    reg_write = 1;
    if (use_pc) reg_src = 1;
    else begin reg_src = 0; result_src = 2; alu_src_a = 1; alu_src_b = 2; alu_control = 0; end
    tick(); idle_ctl();
    m_wr(int'(m_ir[11:7]), use_pc ? m_pc : m_old_pc + 32'd4);
  endtask

  task automatic op_rf_load(input int kind);
    reg_write = 1; result_src = 1; imm_in = 1; imm_src = 4'(kind);
    tick(); idle_ctl();
    m_wr(int'(m_ir[11:7]), load_ext(kind, m_data));
  endtask

  task automatic op_rf_imm();
    reg_write = 1; result_src = 3; alu_src_b = 1; imm_src = 0;
    tick(); idle_ctl();
    m_wr(int'(m_ir[11:7]), imm_i(m_ir));
  endtask

  task automatic op_rf_alu(input int op);
    alu_src_a = 2; alu_src_b = 1; imm_src = 0; alu_control = 4'(op); result_src = 0;
    tick();
    reg_write = 1;
    tick(); idle_ctl();
    m_wr(int'(m_ir[11:7]), m_alu(op, m_rd(int'(m_ir[19:15])), imm_i(m_ir)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1; dbg_sel = 0; mem_rdata = 0;
    idle_ctl();
    model_reset();
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wen", mem_wen, 1'b0);
    chk("rst_err", mem_err, 1'b0);

    // Zero-wait fetch, then recover OldPC+4 into x1
    op_fetch(0, 1'b0, 32'h0050_0093);
    chk("zw_instr", instr, 32'h0050_0093);
    op_rf_link(1'b0);
    check_arch(1);
    dbg_sel = 1; #1;
    chk("zw_oldpc", dbg_data, RESET_PC + 32'd4);

    // Load from 0x100 with three wait states, data written back to x1
    op_fetch(1, 1'b0, 32'h1000_0083);
    check_arch(0);
    op_load(3, 1'b0, 1'b0);
    op_rf_load(9);
    check_arch(1);

    // Control inputs during an open access must be ignored
    op_fetch(3, 1'b1, 32'h0030_0113);
    check_arch(1);
    check_arch(2);

    // Register file edges with 16 entries
    op_fetch(0, 1'b0, 32'h0050_0013); op_rf_imm();
    op_fetch(0, 1'b0, 32'h0070_0A13); op_rf_imm();
    op_fetch(0, 1'b0, 32'h0050_0193); op_rf_imm();
    dbg_sel = 0;  #1; chk("rf_x0", dbg_data, 32'd0);
    dbg_sel = 20; #1; chk("rf_x20", dbg_data, 32'd0);
    dbg_sel = 3;  #1; chk("rf_x3", dbg_data, 32'd5);
    check_arch(3);

    // PC wraps modulo 2^32
    op_fetch(0, 1'b0, 32'hFFC0_0013);
    op_pc_imm();
    chk("pc_top", pc, 32'hFFFF_FFFC);
    op_pc_inc();
    chk("pc_wrap", pc, 32'd0);
    check_arch(3);

    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0, 1: op_fetch($urandom_range(0, 4), 1'($urandom), $urandom);
        2:    op_load($urandom_range(0, 4), 1'($urandom), 1'($urandom));
        3:    op_pc_inc();
        4:    op_pc_imm();
        5:    op_rf_link(1'($urandom));
        6:    op_rf_load($urandom_range(5, 9));
        7:    op_rf_imm();
        default: op_rf_alu($urandom_range(0, 4));
      endcase
      check_arch($urandom_range(0, 31));
    end

`ifdef MC_DP_MEM_TIMEOUT_EN
    begin
      int done_n;
      done_n = 0;
      mem_start = 1; ir_write = 1;
      tick();
      mem_start = 0; ir_write = 0;
      for (int i = 0; i < int'(TIMEOUT); i++) begin
        chk("to_busy", busy, 1'b1);
        done_n += int'(mem_done);
        tick();
      end
      done_n += int'(mem_done);
      chk("to_busy_drop", busy, 1'b0);
      chk("to_err", mem_err, 1'b1);
      chk("to_instr", instr, m_ir);
      m_err = 1;
      tick();
      done_n += int'(mem_done);
      chk("to_no_done", done_n, 0);
      chk("to_err_sticky", mem_err, 1'b1);
    end
`endif
    chk("err_level", mem_err, m_err);

    // Asynchronous reset in the middle of an open access
    op_pc_inc();
    mem_start = 1; ir_write = 1;
    tick();
    mem_start = 0; ir_write = 0;
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #3 reset = 1;
    #1;
    chk("arst_pc", pc, RESET_PC);
    chk("arst_instr", instr, NOP);
    chk("arst_req", mem_req, 1'b0);
    chk("arst_err", mem_err, 1'b0);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("arst_no_done", mem_done, 1'b0);
    reset = 0;
    tick();
    idle_ctl();
    model_reset();
    chk("arst_no_done2", mem_done, 1'b0);
    chk("arst_idle", busy, 1'b0);
    check_arch(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
